// File: rtl/etapa_fetch_pkg.sv
// etapa_fetch_pkg: shared pipeline definitions for the instruction-fetch stage.
//   - XLEN / ENTRY_W     : instruction/address width and hold-buffer entry width
//   - NOP                : instruction value presented on a bubble
//   - DEFAULT_RESET_PC   : default PC loaded on reset
//   - fetch_state_e      : fetch FSM state encoding (IDLE, BUSY, HOLD, DROP)
//   - fetch_entry_t      : (instruction, PC+4) payload held by the hold buffer
//   - word_align()       : clears address bits [1:0]
package etapa_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN;

  localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK       = ~XLEN'(3);

  // Fetch FSM states with fixed encodings for compatibility with older tooling.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_BUSY = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_e;

  // Instruction plus its PC+4, as handed to IF/ID.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] next_pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage : etapa_fetch_pkg

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: one-entry (instruction, PC+4) register used to park a
// memory response that arrived while the pipeline was stalled.
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   load   in  capture d this cycle
//   clear  in  empty the entry (wins over load)
//   d      in  entry to capture
//   q      out stored entry
module fetch_hold_buffer
  import etapa_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t d,
  output fetch_entry_t q
);

  fetch_entry_t entry_q;
  fetch_entry_t entry_d;

  // Next-entry selection.
  always_comb begin
    entry_d = entry_q;
    if (clear) begin
      entry_d = '0;
    end else if (load) begin
      entry_d = d;
    end
  end

  // Entry register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule : fetch_hold_buffer

// File: rtl/etapa_fetch.sv
// etapa_fetch: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the PC, fetches from instruction memory over a req/ready handshake,
// applies branch/jump redirects and presents (instruccion, next_pc, valid)
// to the IF/ID register.
//   clk, rst_n        in  clock, synchronous active-low reset
//   stall             in  IF/ID cannot accept this cycle
//   branch_taken/_target  in  redirect from branch resolution (older, wins)
//   jump/jump_target  in  redirect from ID
//   imem_req/addr     out fetch request and word-aligned address (decoded)
//   imem_ready/data   in  memory response strobe and instruction
//   next_pc           out registered PC+4 of the presented instruction
//   instruccion       out registered instruction (NOP on bubble)
//   valid             out presented instruction is real
module etapa_fetch
  import etapa_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] instruccion,
  output logic            valid
);

  fetch_state_e    state_q,     state_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] instr_q,     instr_d;
  logic [XLEN-1:0] next_pc_q,   next_pc_d;
  logic            valid_q,     valid_d;

  logic            redir;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] pc_plus4;

  logic            buf_load;
  logic            buf_clear;
  fetch_entry_t    buf_in;
  fetch_entry_t    buf_out;

  // Redirect arbitration: branch belongs to the older instruction, so it wins.
  always_comb begin
    redir        = branch_taken | jump;
    redir_target = word_align(branch_taken ? branch_target : jump_target);
  end

  assign pc_plus4 = pc_q + PC_STEP;

  // Parked response for the stall case.
  always_comb begin
    buf_in.instr   = imem_data;
    buf_in.next_pc = pc_plus4;
  end

  fetch_hold_buffer u_hold_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .d     (buf_in),
    .q     (buf_out)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    instr_d     = instr_q;
    next_pc_d   = next_pc_q;
    valid_d     = valid_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;

    // A redirect flushes regardless of stall.
    if (redir) begin
      valid_d = 1'b0;
      instr_d = NOP;
      pc_d    = redir_target;
    end

    unique case (state_q)
      FETCH_IDLE: begin
        // Memory responses are ignored here; always start fetching next cycle.
        state_d = FETCH_BUSY;
      end

      FETCH_BUSY: begin
        if (redir) begin
          if (!imem_ready) begin
            // Request still in flight: keep its address on the bus and drain it.
            state_d     = FETCH_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            instr_d   = imem_data;
            next_pc_d = pc_plus4;
            valid_d   = 1'b1;
            pc_d      = pc_plus4;
          end else begin
            buf_load = 1'b1;
            state_d  = FETCH_HOLD;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP;
        end
      end

      FETCH_HOLD: begin
        if (redir) begin
          buf_clear = 1'b1;
          state_d   = FETCH_BUSY;
        end else if (!stall) begin
          instr_d   = buf_out.instr;
          next_pc_d = buf_out.next_pc;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          buf_clear = 1'b1;
          state_d   = FETCH_BUSY;
        end
      end

      FETCH_DROP: begin
        // The response for the stale address is discarded. A redirect that
        // lands on the same cycle as that response still only retargets pc:
        // the drained request is gone, so fetching restarts from pc.
        if (imem_ready) begin
          state_d = FETCH_BUSY;
        end
      end

      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  // State, PC and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      instr_q     <= NOP;
      next_pc_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      instr_q     <= instr_d;
      next_pc_q   <= next_pc_d;
      valid_q     <= valid_d;
    end
  end

  // Request decode: DROP keeps the stale address stable until it completes.
  always_comb begin
    imem_req  = (state_q == FETCH_BUSY) || (state_q == FETCH_DROP);
    imem_addr = (state_q == FETCH_DROP) ? drop_addr_q : pc_q;
  end

  assign next_pc     = next_pc_q;
  assign instruccion = instr_q;
  assign valid       = valid_q;

endmodule : etapa_fetch

// File: tb/tb_etapa_fetch.sv
// tb_etapa_fetch: directed, table-driven bench for etapa_fetch with a
// behavioural instruction memory of programmable latency.
module tb_etapa_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] next_pc;
  logic [31:0] instruccion;
  logic        valid;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model controls.
  int   lat = 0;
  int   wait_cnt = 0;
  logic ready_force = 1'b0;

  always #5 clk = ~clk;

  etapa_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .next_pc       (next_pc),
    .instruccion   (instruccion),
    .valid         (valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'hA5A5_0000);
  endfunction

  assign imem_data  = mem_word(imem_addr);
  assign imem_ready = ready_force | (imem_req & (wait_cnt == lat));

  always @(posedge clk) begin
    if (!rst_n || imem_ready || !imem_req) wait_cnt <= 0;
    else                                   wait_cnt <= wait_cnt + 1;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [31:0] ei,
                            input logic [31:0] enp, input logic ereq, input logic [31:0] ea);
    check32({tag, "_valid"}, 32'(valid), 32'(ev));
    check32({tag, "_instr"}, instruccion, ei);
    check32({tag, "_next_pc"}, next_pc, enp);
    check32({tag, "_req"}, 32'(imem_req), 32'(ereq));
    check32({tag, "_addr"}, imem_addr, ea);
  endtask

  typedef struct {
    int          lat;
    logic        stall;
    logic        bt;
    logic [31:0] btgt;
    logic        jp;
    logic [31:0] jtgt;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] enp;
    logic        ereq;
    logic [31:0] ea;
  } vec_t;

  function automatic vec_t mk(input int l, input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic ev,
                              input logic [31:0] ei, input logic [31:0] enp,
                              input logic ereq, input logic [31:0] ea);
    vec_t v;
    v.lat = l; v.stall = s; v.bt = b; v.btgt = bt; v.jp = j; v.jtgt = jt;
    v.ev = ev; v.ei = ei; v.enp = enp; v.ereq = ereq; v.ea = ea;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    // Expected values are the outputs seen after the clock edge on which the
    // record's inputs were applied.
    // zero-wait streaming from reset
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  1, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h2008_0005, 32'h4,  1, 32'h4);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0004, 32'h8,  1, 32'h8);
    // stall 3 cycles while the response for 8 arrives
    vecs[3]  = mk(0, 1, 0, 0, 0, 0, 1, 32'hA5A5_0004, 32'h8,  0, 32'h8);
    vecs[4]  = mk(0, 1, 0, 0, 0, 0, 1, 32'hA5A5_0004, 32'h8,  0, 32'h8);
    vecs[5]  = mk(0, 1, 0, 0, 0, 0, 1, 32'hA5A5_0004, 32'h8,  0, 32'h8);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0008, 32'hC,  1, 32'hC);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA5A5_000C, 32'h10, 1, 32'h10);
    // 3-cycle latency on 0x10, branch to 0x40 while pending
    vecs[8]  = mk(3, 0, 0, 0, 0, 0, 0, 32'h0,         32'h10, 1, 32'h10);
    vecs[9]  = mk(3, 0, 1, 32'h40, 0, 0, 0, 32'h0,    32'h10, 1, 32'h10);
    vecs[10] = mk(3, 0, 0, 0, 0, 0, 0, 32'h0,         32'h10, 1, 32'h10);
    vecs[11] = mk(3, 0, 0, 0, 0, 0, 0, 32'h0,         32'h10, 1, 32'h40);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0040, 32'h44, 1, 32'h44);
    // branch + jump together under stall: branch wins
    vecs[13] = mk(0, 1, 1, 32'h80, 1, 32'hC0, 0, 32'h0, 32'h44, 1, 32'h80);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0080, 32'h84, 1, 32'h84);
    // misaligned jump target is word-aligned
    vecs[15] = mk(0, 0, 0, 0, 1, 32'h103, 0, 32'h0,   32'h84, 1, 32'h100);
    // PC wrap at the top of the address space
    vecs[16] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h84, 1, 32'hFFFF_FFFC);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 1, 32'h5A5A_FFFC, 32'h0, 1, 32'h0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 32'h2008_0005, 32'h4, 1, 32'h4);

    rst_n = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      lat           = vecs[i].lat;
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].bt;
      branch_target = vecs[i].btgt;
      jump          = vecs[i].jp;
      jump_target   = vecs[i].jtgt;
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("v%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].enp,
                 vecs[i].ereq, vecs[i].ea);
    end

    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;

    // Reset asserted during DROP with the memory ready line pulsing.
    lat = 3;
    branch_taken = 1'b1; branch_target = 32'h200;
    @(posedge clk); @(negedge clk);
    branch_taken = 1'b0;
    check_outs("drop_enter", 1'b0, 32'h0, 32'h4, 1'b1, 32'h4);

    rst_n = 1'b0; ready_force = 1'b1;
    @(posedge clk); @(negedge clk);
    check_outs("rst_in_drop", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    ready_force = 1'b0;
    @(posedge clk); @(negedge clk);
    ready_force = 1'b1;
    @(posedge clk); @(negedge clk);
    check_outs("rst_hold", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    ready_force = 1'b0; lat = 0;
    check_outs("rst_first_req", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    @(posedge clk); @(negedge clk);
    check_outs("rst_first_data", 1'b1, 32'h2008_0005, 32'h4, 1'b1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_etapa_fetch

// File: doc/etapa_fetch.md
# etapa_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the program counter, issues requests to instruction memory over a req/ready handshake, and applies branch and jump redirects. It presents each fetched instruction and its PC+4 with a valid strobe that, together with the hazard-unit stall, drives the IF/ID enable.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  from hazard unit; IF/ID cannot accept this cycle.
- branch_taken  in  1  redirect request from the branch-resolution stage.
- branch_target  in  32  target address for branch_taken.
- jump  in  1  redirect request from ID.
- jump_target  in  32  target address for jump.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  response strobe; may assert in the same cycle as imem_req.
- imem_data  in  32  instruction, valid when imem_ready=1.
- next_pc  out  32  registered PC+4 of the presented instruction; feeds IF/ID nextPcIN.
- instruccion  out  32  registered instruction; feeds IF/ID instruccionIN.
- valid  out  1  instruccion/next_pc hold a real instruction; 0 means bubble.

## Operation
- State machine with four states:
  - IDLE: imem_req=0. Entered only from reset; always goes to BUSY on the next cycle.
  - BUSY: imem_req=1, imem_addr=pc.
  - HOLD: a response was captured while stall=1; imem_req=0.
  - DROP: imem_req=1 with the stale address; waits for the in-flight response and discards it.
- Redirect: redir = branch_taken | jump. If both are asserted, branch_taken wins because it belongs to the older instruction. The target is that of the winning source.
- BUSY, imem_ready=1, no redir, stall=0:
  - instruccion<=imem_data, next_pc<=pc+4, valid<=1.
  - pc<=pc+4; stay BUSY.
- BUSY, imem_ready=1, no redir, stall=1:
  - Capture imem_data and pc+4 into the hold buffer; go HOLD.
  - Outputs unchanged.
- BUSY, imem_ready=0, no redir: if stall=0 then valid<=0 and instruccion<=NOP (32'h0); if stall=1, outputs hold.
- HOLD, stall=0, no redir:
  - Outputs<=buffer, valid<=1.
  - pc<=pc+4; go BUSY.
- HOLD, stall=1: everything holds.
- Redir in any state (flush overrides stall): valid<=0, instruccion<=NOP, pc<=target. Next state:
  - From BUSY with imem_ready=0: DROP.
  - From BUSY with imem_ready=1, from HOLD, or from IDLE: BUSY. In BUSY the response is discarded; in HOLD the buffer is discarded.
- DROP: on imem_ready, discard the data and go BUSY with the redirected pc. A second redirect while in DROP updates pc and stays in DROP.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. imem_addr[1:0] is always 0, and targets are used with bits [1:0] forced to 0.
- Reset (rst_n=0 at a clock edge, including mid-transaction):
  - state=IDLE, pc=RESET_PC, imem_req=0, valid=0, instruccion=0, next_pc=0.
  - Any outstanding memory response is ignored for the cycle(s) the block is in reset and IDLE.

## Timing
- All outputs are registered except imem_req and imem_addr, which decode from state and pc.
- Latency: an imem_ready at cycle N appears on instruccion/valid at N+1.
- Throughput: with zero-wait memory (ready in the same cycle as req), one instruction per cycle.
- First request is issued in the second cycle after rst_n rises (one IDLE cycle).
- Redirect-to-bubble: valid=0 in the cycle after redir. The target instruction is valid no earlier than 2 cycles after redir, or later after the DROP drain completes.
- stall must be sampled at the same edge as IF/ID enable. The IF/ID enable is valid & ~stall, or ~stall alone for bubble propagation.

## Structure
- Shared pipeline package holds:
  - the fetch state enum (IDLE, BUSY, HOLD, DROP);
  - the NOP constant 32'h0000_0000;
  - the default RESET_PC;
  - the instruction and address width constant of 32.
- One sub-module: fetch_hold_buffer, a one-entry 64-bit register (instruction, PC+4) with load and clear controls. Redirect priority, the pc register and the FSM stay in etapa_fetch.

## Test plan
- Reset release, zero-wait memory returning 32'h2008_0005 at address 0 -> imem_addr 0,4,8 on consecutive cycles; instruccion=32'h2008_0005 and next_pc=4 with valid=1 one cycle after the first ready.
- stall=1 for 3 cycles while a response for address 8 arrives -> HOLD, imem_req=0, outputs frozen; after stall drops, instruccion = data@8, next_pc=12, next request at 12.
- branch_taken=1 with target 32'h40 while a 3-cycle-latency request to 0x10 is pending -> DROP, the 0x10 data never reaches valid=1, next request at 0x40, valid=0 during the drain.
- branch_taken and jump asserted together with targets 0x80 and 0xC0, and stall=1 -> valid=0 next cycle, next fetch address 0x80.
- pc=32'hFFFF_FFFC, zero-wait memory -> next_pc=0, next imem_addr=0.
- rst_n=0 asserted during DROP with imem_ready pulsing -> all outputs 0, imem_req=0; after release, first fetch at RESET_PC.
